// File: rtl/rx_sample_gate_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rx_sample_gate_pkg: register map, source encodings, CTRL fields     |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package rx_sample_gate_pkg;

  localparam logic [7:0] SR_CTRL    = 8'd0;
  localparam logic [7:0] SR_DECIM   = 8'd1;
  localparam logic [7:0] SR_CONST   = 8'd2;
  localparam logic [7:0] SR_TIMEOUT = 8'd3;

  typedef enum logic [1:0] {
    SRC_ADC   = 2'd0,
    SRC_RAMP  = 2'd1,
    SRC_CONST = 2'd2,
    SRC_ZERO  = 2'd3
  } src_sel_e;

  localparam int CTRL_SRC_LSB   = 0;
  localparam int CTRL_SRC_MSB   = 1;
  localparam int CTRL_SWAP_BIT  = 2;
  localparam int CTRL_CLEAR_BIT = 3;

  function automatic logic [31:0] swap_halves(input logic [31:0] s);
    return {s[15:0], s[31:16]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/rx_sample_gate_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rx_sample_gate_if: settings/readback bus, ADC input and RX output   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
interface rx_sample_gate_if;
  logic        set_stb;
  logic [7:0]  set_addr;
  logic [31:0] set_data;
  logic [7:0]  rb_addr;
  logic [63:0] rb_data;
  logic [15:0] adc_i;
  logic [15:0] adc_q;
  logic        adc_stb;
  logic        rx_running;
  logic [31:0] rx;
  logic        rx_stb;

  modport master (
    output set_stb, set_addr, set_data, rb_addr, adc_i, adc_q, adc_stb, rx_running,
    input  rb_data, rx, rx_stb
  );

  modport slave (
    input  set_stb, set_addr, set_data, rb_addr, adc_i, adc_q, adc_stb, rx_running,
    output rb_data, rx, rx_stb
  );
endinterface
`default_nettype wire

// File: rtl/rx_gate_watchdog.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rx_gate_watchdog: strobe-gap counter with sticky gap_err            |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module rx_gate_watchdog (
  input  logic        clk,
  input  logic        reset,
  input  logic        strobe,
  input  logic        running,
  input  logic [15:0] timeout,
  input  logic        clear,
  output logic        gap_err
);
  logic [15:0] gap_cnt_q;
  logic [15:0] gap_cnt_d;
  logic        gap_err_q;
  logic        gap_err_d;
  logic        enabled;

  always_comb begin
    enabled   = running && (timeout != 16'd0);
    gap_cnt_d = gap_cnt_q;
    if (clear || !enabled || strobe) gap_cnt_d = 16'd0;
    else if (gap_cnt_q < timeout)    gap_cnt_d = gap_cnt_q + 16'd1;
    else                             gap_cnt_d = timeout;
    // Flag on the same edge the count reaches the limit, not one later.
    gap_err_d = !clear && (gap_err_q || (enabled && (gap_cnt_d == timeout)));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gap_cnt_q <= 16'd0;
      gap_err_q <= 1'b0;
    end else begin
      gap_cnt_q <= gap_cnt_d;
      gap_err_q <= gap_err_d;
    end
  end

  assign gap_err = gap_err_q;
endmodule
`default_nettype wire

// File: rtl/setting_reg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | setting_reg: one settings-bus register, loaded when addr matches    |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module setting_reg #(
  parameter logic [7:0] MY_ADDR  = 8'd0,
  parameter int         WIDTH    = 32,
  parameter logic [WIDTH-1:0] AT_RESET = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             strobe,
  input  logic [7:0]       addr,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out
);
  logic [WIDTH-1:0] value_q;
  logic [WIDTH-1:0] value_d;

  always_comb begin
    value_d = value_q;
    if (strobe && (addr == MY_ADDR)) value_d = data_in;
  end

  always_ff @(posedge clk) begin
    if (reset) value_q <= AT_RESET;
    else       value_q <= value_d;
  end

  assign data_out = value_q;
endmodule
`default_nettype wire

// File: rtl/rx_sample_gate.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rx_sample_gate: RX source select, I/Q swap, decimation, counters.   |
// | Optional ramp source: define RX_SAMPLE_GATE_PATTERN_EN. Rev 1.0     |
// +--------------------------------------------------------------------+
module rx_sample_gate
  import rx_sample_gate_pkg::*;
#(
  parameter logic [7:0] SR_BASE = 8'd200,
  parameter logic [7:0] RB_ADDR = 8'd20
) (
  input  logic           clk,
  input  logic           reset,
  rx_sample_gate_if.slave bus
);
  logic [2:0]  ctrl;
  logic [15:0] decim;
  logic [31:0] const_val;
  logic [15:0] timeout;
  src_sel_e    src_sel;
  logic        iq_swap;
  logic        decim_wr;
  logic        clear;
  logic        emit;
  logic        count_inc;
  logic        gap_err;
  logic [31:0] sample;
  logic [31:0] ramp_sample;
  logic [31:0] status;

  logic [15:0] dcnt_q, dcnt_d;
  logic [31:0] rx_q, rx_d;
  logic        rx_stb_q, rx_stb_d;
  logic [31:0] sample_count_q, sample_count_d;
  logic        sat_q, sat_d;

  setting_reg #(.MY_ADDR(SR_BASE + SR_CTRL), .WIDTH(3)) u_sr_ctrl (
    .clk(clk), .reset(reset), .strobe(bus.set_stb), .addr(bus.set_addr),
    .data_in(bus.set_data[2:0]), .data_out(ctrl)
  );
  setting_reg #(.MY_ADDR(SR_BASE + SR_DECIM), .WIDTH(16)) u_sr_decim (
    .clk(clk), .reset(reset), .strobe(bus.set_stb), .addr(bus.set_addr),
    .data_in(bus.set_data[15:0]), .data_out(decim)
  );
  setting_reg #(.MY_ADDR(SR_BASE + SR_CONST), .WIDTH(32)) u_sr_const (
    .clk(clk), .reset(reset), .strobe(bus.set_stb), .addr(bus.set_addr),
    .data_in(bus.set_data), .data_out(const_val)
  );
  setting_reg #(.MY_ADDR(SR_BASE + SR_TIMEOUT), .WIDTH(16)) u_sr_timeout (
    .clk(clk), .reset(reset), .strobe(bus.set_stb), .addr(bus.set_addr),
    .data_in(bus.set_data[15:0]), .data_out(timeout)
  );

  // clear is never stored: the write itself is the one-cycle pulse.
  always_comb begin
    src_sel  = src_sel_e'(ctrl[CTRL_SRC_MSB:CTRL_SRC_LSB]);
    iq_swap  = ctrl[CTRL_SWAP_BIT];
    decim_wr = bus.set_stb && (bus.set_addr == SR_BASE + SR_DECIM);
    clear    = bus.set_stb && (bus.set_addr == SR_BASE + SR_CTRL)
               && bus.set_data[CTRL_CLEAR_BIT];
  end

`ifdef RX_SAMPLE_GATE_PATTERN_EN
  logic [15:0] ramp_q, ramp_d;

  always_comb ramp_d = emit ? ramp_q + 16'd1 : ramp_q;

  always_ff @(posedge clk) begin
    if (reset) ramp_q <= 16'd0;
    else       ramp_q <= ramp_d;
  end

  assign ramp_sample = {ramp_q, ~ramp_q};
`else
  assign ramp_sample = {bus.adc_i, bus.adc_q};
`endif

  always_comb begin
    emit   = bus.adc_stb && (dcnt_q == 16'd0);
    dcnt_d = dcnt_q;
    if (decim_wr)         dcnt_d = 16'd0;
    else if (bus.adc_stb) dcnt_d = emit ? decim : dcnt_q - 16'd1;

    sample = 32'd0;
    case (src_sel)
      SRC_ADC:   sample = {bus.adc_i, bus.adc_q};
      SRC_RAMP:  sample = ramp_sample;
      SRC_CONST: sample = const_val;
      SRC_ZERO:  sample = 32'd0;
    endcase
    if (iq_swap) sample = swap_halves(sample);

    rx_stb_d = emit;
    rx_d     = emit ? sample : rx_q;
  end

  always_comb begin
    count_inc      = emit && bus.rx_running;
    sample_count_d = sample_count_q;
    sat_d          = sat_q;
    if (clear) begin
      sample_count_d = 32'd0;
      sat_d          = 1'b0;
    end else if (count_inc) begin
      if (sample_count_q == 32'hFFFF_FFFF) sat_d = 1'b1;
      else                                 sample_count_d = sample_count_q + 32'd1;
    end
  end

  rx_gate_watchdog u_watchdog (
    .clk(clk), .reset(reset), .strobe(bus.adc_stb), .running(bus.rx_running),
    .timeout(timeout), .clear(clear), .gap_err(gap_err)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      dcnt_q         <= 16'd0;
      rx_q           <= 32'd0;
      rx_stb_q       <= 1'b0;
      sample_count_q <= 32'd0;
      sat_q          <= 1'b0;
    end else begin
      dcnt_q         <= dcnt_d;
      rx_q           <= rx_d;
      rx_stb_q       <= rx_stb_d;
      sample_count_q <= sample_count_d;
      sat_q          <= sat_d;
    end
  end

  always_comb begin
    status      = {29'd0, bus.rx_running, sat_q, gap_err};
    bus.rb_data = (bus.rb_addr == RB_ADDR) ? {sample_count_q, status} : 64'd0;
  end

  assign bus.rx     = rx_q;
  assign bus.rx_stb = rx_stb_q;
endmodule
`default_nettype wire

// File: tb/tb_rx_sample_gate.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_rx_sample_gate: vector table + scoreboard bench for rx_sample_gate|
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_rx_sample_gate;
  localparam logic [7:0] BASE   = 8'd200;
  localparam logic [7:0] O_CTRL = 8'd0;
  localparam logic [7:0] O_DEC  = 8'd1;
  localparam logic [7:0] O_CST  = 8'd2;
  localparam logic [7:0] O_TMO  = 8'd3;

  typedef struct {
    logic [1:0]  src;
    logic        swap;
    logic [31:0] cst;
    logic [15:0] i;
    logic [15:0] q;
    logic [31:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  rx_sample_gate_if bus();

  rx_sample_gate dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int m_decim  = 0;
  int m_dcnt   = 0;
  logic last_emit;
  logic [31:0] sbq[$];
  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One clock: drive at negedge, predict, then compare after the edge.
  task automatic step(input logic stb, input logic [15:0] i, input logic [15:0] q,
                      input logic [31:0] exp);
    logic exp_emit;
    logic [31:0] want;
    bus.adc_stb = stb;
    bus.adc_i   = i;
    bus.adc_q   = q;
    exp_emit = stb && (m_dcnt == 0);
    if (exp_emit) sbq.push_back(exp);
    if (stb) m_dcnt = exp_emit ? m_decim : m_dcnt - 1;
    @(posedge clk);
    @(negedge clk);
    bus.adc_stb = 1'b0;
    bus.set_stb = 1'b0;
    check("rx_stb", {63'd0, bus.rx_stb}, {63'd0, exp_emit});
    last_emit = bus.rx_stb;
    if (bus.rx_stb || exp_emit) begin
      if (sbq.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL scoreboard: rx=%h strobed with no expected sample", bus.rx);
      end else begin
        want = sbq.pop_front();
        if (bus.rx_stb) check("rx", {32'd0, bus.rx}, {32'd0, want});
      end
    end
  endtask

  task automatic wr(input logic [7:0] off, input logic [31:0] data);
    bus.set_stb  = 1'b1;
    bus.set_addr = BASE + off;
    bus.set_data = data;
    step(1'b0, 16'h0, 16'h0, 32'h0);
    if (off == O_DEC) begin
      m_decim = int'(data[15:0]);
      m_dcnt  = 0;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    m_decim = 0;
    m_dcnt  = 0;
    sbq.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL sim_timeout: bench did not finish, got no summary, expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] exp;
    logic [11:0] emask;
    logic [15:0] k16;

    vecs[0] = '{2'd0, 1'b0, 32'h0,         16'h1234, 16'hABCD, 32'h1234ABCD};
    vecs[1] = '{2'd0, 1'b1, 32'h0,         16'h1234, 16'hABCD, 32'hABCD1234};
    vecs[2] = '{2'd2, 1'b0, 32'hDEADBEEF, 16'h1111, 16'h2222, 32'hDEADBEEF};
    vecs[3] = '{2'd2, 1'b1, 32'hDEADBEEF, 16'h1111, 16'h2222, 32'hBEEFDEAD};
    vecs[4] = '{2'd3, 1'b0, 32'hDEADBEEF, 16'h5555, 16'h6666, 32'h00000000};
    vecs[5] = '{2'd3, 1'b1, 32'hDEADBEEF, 16'h5555, 16'h6666, 32'h00000000};
    vecs[6] = '{2'd0, 1'b0, 32'h0,         16'h8000, 16'h0001, 32'h80000001};

    bus.set_stb = 1'b0; bus.set_addr = 8'd0; bus.set_data = 32'd0;
    bus.rb_addr = 8'd20; bus.adc_i = 16'd0; bus.adc_q = 16'd0;
    bus.adc_stb = 1'b0; bus.rx_running = 1'b0;
    @(negedge clk);
    do_reset();

    check("reset_rx_stb", {63'd0, bus.rx_stb}, 64'd0);
    check("reset_rx", {32'd0, bus.rx}, 64'd0);
    check("reset_rb", bus.rb_data, 64'd0);

    // Pass-through, adc_stb on every cycle.
    for (int k = 0; k < 4; k++) step(1'b1, 16'h1234, 16'hABCD, 32'h1234ABCD);

    foreach (vecs[k]) begin
      wr(O_CTRL, {29'd0, vecs[k].swap, vecs[k].src});
      wr(O_CST, vecs[k].cst);
      step(1'b1, vecs[k].i, vecs[k].q, vecs[k].exp);
    end
    wr(O_CTRL, 32'd0);

    // Decimation by 4: strobes 1, 5, 9 pass.
    wr(O_DEC, 32'd3);
    emask = 12'd0;
    for (int k = 1; k <= 12; k++) begin
      k16 = 16'(k);
      step(1'b1, k16, ~k16, {k16, ~k16});
      emask[k-1] = last_emit;
      step(1'b0, 16'h0, 16'h0, 32'h0);
    end
    check("decim_mask", {52'd0, emask}, {52'd0, 12'b0001_0001_0001});

    wr(O_DEC, 32'd3);
    step(1'b1, 16'h00A1, 16'h00B1, 32'h00A100B1);
    step(1'b1, 16'h00A2, 16'h00B2, 32'h00A200B2);
    wr(O_DEC, 32'd3);
    step(1'b1, 16'h00A3, 16'h00B3, 32'h00A300B3);
    check("decim_rewrite_emit", {63'd0, last_emit}, 64'd1);

    // Ramp source, then ramp with swap.
    do_reset();
    wr(O_CTRL, 32'd1);
    for (int k = 0; k < 3; k++) begin
      k16 = 16'(k);
`ifdef RX_SAMPLE_GATE_PATTERN_EN
      exp = {k16, ~k16};
`else
      exp = {16'h1000 + k16, 16'h2000 + k16};
`endif
      step(1'b1, 16'h1000 + k16, 16'h2000 + k16, exp);
    end
    do_reset();
    wr(O_CTRL, 32'd5);
`ifdef RX_SAMPLE_GATE_PATTERN_EN
    exp = 32'hFFFF0000;
`else
    exp = 32'hABCD1234;
`endif
    step(1'b1, 16'h1234, 16'hABCD, exp);

    // Watchdog.
    do_reset();
    bus.rx_running = 1'b1;
    wr(O_TMO, 32'd10);
    step(1'b1, 16'h0101, 16'h0202, 32'h01010202);
    for (int k = 0; k < 9; k++) step(1'b0, 16'h0, 16'h0, 32'h0);
    check("gap_err_at_9", {63'd0, bus.rb_data[0]}, 64'd0);
    step(1'b0, 16'h0, 16'h0, 32'h0);
    check("gap_err_at_10", {63'd0, bus.rb_data[0]}, 64'd1);
    check("status_running", {63'd0, bus.rb_data[2]}, 64'd1);
    wr(O_CTRL, 32'd8);
    check("gap_err_cleared", {63'd0, bus.rb_data[0]}, 64'd0);
    wr(O_TMO, 32'd0);
    for (int k = 0; k < 30; k++) step(1'b0, 16'h0, 16'h0, 32'h0);
    check("gap_err_timeout0", {63'd0, bus.rb_data[0]}, 64'd0);

    // Sample counter saturation and clear.
    do_reset();
    bus.rx_running = 1'b1;
    force dut.sample_count_d = 32'hFFFF_FFFE;
    @(posedge clk);
    @(negedge clk);
    release dut.sample_count_d;
    check("count_preload", {32'd0, bus.rb_data[63:32]}, 64'hFFFF_FFFE);
    step(1'b1, 16'h0001, 16'h0002, 32'h00010002);
    check("count_max", {32'd0, bus.rb_data[63:32]}, 64'hFFFF_FFFF);
    step(1'b1, 16'h0003, 16'h0004, 32'h00030004);
    step(1'b1, 16'h0005, 16'h0006, 32'h00050006);
    check("count_hold", {32'd0, bus.rb_data[63:32]}, 64'hFFFF_FFFF);
    check("sat_set", {63'd0, bus.rb_data[1]}, 64'd1);
    bus.set_stb  = 1'b1;
    bus.set_addr = BASE + O_CTRL;
    bus.set_data = 32'd8;
    step(1'b1, 16'h0007, 16'h0008, 32'h00070008);
    check("count_clear_wins", {32'd0, bus.rb_data[63:32]}, 64'd0);
    check("sat_cleared", {63'd0, bus.rb_data[1]}, 64'd0);
    step(1'b1, 16'h0009, 16'h000A, 32'h0009000A);
    check("count_after_clear", {32'd0, bus.rb_data[63:32]}, 64'd1);

    // Reset in the middle of a decimated stream.
    do_reset();
    bus.rx_running = 1'b0;
    wr(O_DEC, 32'd2);
    step(1'b1, 16'h1111, 16'h2222, 32'h11112222);
    step(1'b1, 16'h3333, 16'h4444, 32'h33334444);
    step(1'b1, 16'h5555, 16'h6666, 32'h55556666);
    bus.adc_stb = 1'b1;
    bus.adc_i   = 16'h7777;
    bus.adc_q   = 16'h8888;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    bus.adc_stb = 1'b0;
    m_decim = 0;
    m_dcnt  = 0;
    sbq.delete();
    check("midreset_rx_stb", {63'd0, bus.rx_stb}, 64'd0);
    check("midreset_rx", {32'd0, bus.rx}, 64'd0);
    step(1'b1, 16'h9999, 16'hAAAA, 32'h9999AAAA);
    check("post_reset_emit", {63'd0, last_emit}, 64'd1);
    step(1'b1, 16'hBBBB, 16'hCCCC, 32'hBBBBCCCC);

    if (sbq.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d samples left, expected 0", sbq.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
